// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory handshake bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              dm_rd_en;
  logic              dm_wr_en;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_rd_en, dm_wr_en, dm_addr, dm_wdata,
    input  mem_rdata, mem_ready,
    output if_rdata, if_valid, if_stall,
    output dm_rdata, dm_valid, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    output dm_rd_en, dm_wr_en, dm_addr, dm_wdata,
    output mem_rdata, mem_ready,
    input  if_rdata, if_valid, if_stall,
    input  dm_rdata, dm_valid, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_nxt;

  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic              if_valid_q,  if_valid_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
  logic              dm_valid_q,  dm_valid_d;

  logic              dm_pend;
  logic              if_pend;
  logic              force_fetch;
  logic              grant_dm;
  logic              grant_if;

  // Data wins unless the fetch side has already lost STARVE_LIMIT times in a row.
  always_comb begin
    dm_pend     = bus.dm_rd_en | bus.dm_wr_en;
    if_pend     = bus.if_req & ~bus.if_flush;
    force_fetch = if_pend && (starve_cnt == CNT_MAX);
    grant_dm    = (state == IDLE) && dm_pend && !force_fetch;
    grant_if    = (state == IDLE) && if_pend && !grant_dm;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_dm) begin
          state_nxt = DATA;
        end else if (grant_if) begin
          state_nxt = FETCH;
        end
      end
      DATA: begin
        if (bus.mem_ready) begin
          state_nxt = IDLE;
        end
      end
      FETCH: begin
        if (bus.mem_ready) begin
          state_nxt = IDLE;
        end else if (bus.if_flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.mem_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    starve_nxt  = starve_cnt;
    case (state)
      IDLE: begin
        if (grant_dm) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_wr_en;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          if (if_pend && (starve_cnt != CNT_MAX)) begin
            starve_nxt = starve_cnt + CNT_W'(1);
          end
        end else if (grant_if) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          starve_nxt = '0;
        end
      end
      DATA: begin
        if (bus.mem_ready) begin
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = bus.mem_rdata;
          end
        end
      end
      FETCH: begin
        // A flush landing on the completing cycle still swallows the instruction.
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          if (!bus.if_flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end
      end
      DRAIN: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
        end
      end
      default: mem_req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_valid_q  <= dm_valid_d;
      starve_cnt  <= starve_nxt;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.if_stall  = bus.if_req & ~bus.if_flush & ~if_valid_q;
  assign bus.dm_stall  = dm_pend & ~dm_valid_q;

endmodule
